// File: rtl/mdu_pkg.sv
// Shared encodings for the integer multiply/divide unit: op codes used by the
// instruction decoder, FSM state encoding and the iteration count.
package mdu_pkg;

    localparam int MDU_ITER = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_CALC = 2'd1,
        MDU_ADJ  = 2'd2
    } mdu_state_e;

    // Divide ops share op[1]; signed ops have op[0] clear.
    function automatic logic is_div_op(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Multiply: radix-2 shift-add, accumulator {hi, lo} with the multiplier in lo.
// Divide: restoring step, dividend shifts out of acc[W-1:0] into the partial
// remainder; the quotient bit is returned separately and acc[0] is left clear.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH:0]       rem,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_next,
    output logic [WIDTH:0]       rem_next,
    output logic                 q_bit
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // Single shift-add or restoring-subtract iteration
    always_comb begin
        sum      = '0;
        shifted  = '0;
        diff     = '0;
        acc_next = acc;
        rem_next = rem;
        q_bit    = 1'b0;
        if (!is_div) begin
            sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            // rem < divisor always holds, so the shifted value fits in WIDTH+1 bits
            shifted  = {rem, acc[WIDTH-1]};
            diff     = shifted - {2'b00, operand};
            q_bit    = ~diff[WIDTH+1];
            rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// Works on magnitudes for 32 iterations, then applies sign fix-up and commits
// HI/LO in a single adjust cycle. Fixed 33-cycle latency for every op.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdu_state_e           state;
    logic [4:0]           cnt;
    logic [1:0]           op_q;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_zero;
    logic [WIDTH-1:0]     operand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;

    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH:0]       rem_next;
    logic                 q_bit;

    logic                 rs_neg;
    logic                 rt_neg;
    logic [WIDTH-1:0]     rs_mag;
    logic [WIDTH-1:0]     rt_mag;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     hi_new;
    logic [WIDTH-1:0]     lo_new;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_op(op_q)),
        .acc      (acc),
        .rem      (rem),
        .operand  (operand),
        .acc_next (acc_next),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Operand sign flags and magnitudes; unsigned ops pass raw values
    always_comb begin
        rs_neg = is_signed_op(op_i) & rs_i[WIDTH-1];
        rt_neg = is_signed_op(op_i) & rt_i[WIDTH-1];
        rs_mag = magnitude(rs_i, rs_neg);
        rt_mag = magnitude(rt_i, rt_neg);
    end

    // Sign fix-up of the finished magnitudes into HI/LO values
    always_comb begin
        prod   = neg_q ? -acc : acc;
        hi_new = prod[2*WIDTH-1:WIDTH];
        lo_new = prod[WIDTH-1:0];
        if (is_div_op(op_q)) begin
            // Divide by zero: quotient is all ones; remainder naturally returns rs
            lo_new = div_zero ? '1 : magnitude(acc[WIDTH-1:0], neg_q);
            hi_new = magnitude(rem[WIDTH-1:0], neg_r);
        end
    end

    // Datapath latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk_i) begin
        if (state == MDU_IDLE && start_i) begin
            op_q     <= op_i;
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (rt_i == '0);
            operand  <= is_div_op(op_i) ? rt_mag : rs_mag;
            acc      <= {{WIDTH{1'b0}}, (is_div_op(op_i) ? rs_mag : rt_mag)};
            rem      <= '0;
        end else if (state == MDU_CALC) begin
            acc <= {acc_next[2*WIDTH-1:1], acc_next[0] | q_bit};
            rem <= rem_next;
        end
    end

    // Control FSM, iteration counter, HI/LO registers and status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= MDU_IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (start_i) begin
                        state  <= MDU_CALC;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end else begin
                        if (mthi_i) hi_o <= rs_i;
                        if (mtlo_i) lo_o <= rs_i;
                    end
                end
                MDU_CALC: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(MDU_ITER - 1)) state <= MDU_ADJ;
                end
                MDU_ADJ: begin
                    state  <= MDU_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    hi_o   <= hi_new;
                    lo_o   <= lo_new;
                end
                default: begin
                    state  <= MDU_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
